dmem_access_ctrl: RTL and testbench

Sequences every access to the multi-cycle single-port data memory and shares that memory between the pipeline MEM stage and a program/data loader port. The block issues one access at a time, counts out the memory latency and captures read data. It stalls the pipeline until the MEM-stage access completes and prevents the loader from being starved. It sits between the MEM stage (mem_we, mem_re, alu_out, reg_out_b, mem_out) and the data memory macro.

---
 rtl/dmem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Shares a multi-cycle, single-port data memory between the pipeline MEM stage
// and a program/data loader port. It runs one access at a time:
// IDLE -> ISSUE (1 cycle) -> WAIT (LATENCY cycles) -> DONE (1 cycle) -> IDLE.
// Read data is captured on the edge that ends the last WAIT cycle.
//
// The pipeline normally wins arbitration. After STARVE_LIMIT consecutive
// pipeline grants while the loader is waiting, the loader is granted once.
//
// Parameters
//   LATENCY      cycles from the dm_en cycle to valid dm_rdata (>= 1)
//   STARVE_LIMIT pipeline grants allowed while ld_req is pending
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_we, mem_re        MEM-stage store / load request (level)
//   alu_out, reg_out_b    MEM-stage address / store data
//   mem_out               MEM-stage load data (registered)
//   stall                 freeze pipeline (combinational)
//   ld_req, ld_we         loader request (held until ld_done), write select
//   ld_addr, ld_wdata     loader address / write data
//   ld_rdata, ld_done     loader read data (registered), completion pulse
//   busy                  controller not idle
//   dm_en, dm_we          memory strobe (ISSUE only) and qualified write enable
//   dm_addr, dm_wdata     memory address / write data
//   dm_rdata              memory read data, valid LATENCY cycles after dm_en
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_out_b,
    output logic [31:0] mem_out,
    output logic        stall,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] ld_rdata,
    output logic        ld_done,
    output logic        busy,
    output logic        dm_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_PIPE,
        OWN_LD
    } owner_t;

    state_t        state_q,    state_d;
    owner_t        owner_q,    owner_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic [CW-1:0] lat_q,      lat_d;
    logic [31:0]   addr_q,     addr_d;
    logic          we_q,       we_d;
    logic [31:0]   wdata_q,    wdata_d;
    logic [31:0]   mem_out_q,  mem_out_d;
    logic [31:0]   ld_rdata_q, ld_rdata_d;

    logic pipe_req;
    logic grant_pipe;
    logic grant_ld;

    assign pipe_req = mem_re | mem_we;

    // The loader wins when it is alone or when the pipeline has used up its
    // allowance of consecutive grants; otherwise the pipeline wins.
    assign grant_ld   = ld_req & (~pipe_req | (starve_q == SW'(STARVE_LIMIT)));
    assign grant_pipe = pipe_req & ~grant_ld;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mem_out_d  = mem_out_q;
        ld_rdata_d = ld_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_ld) begin
                    state_d  = S_ISSUE;
                    owner_d  = OWN_LD;
                    addr_d   = ld_addr;
                    we_d     = ld_we;
                    wdata_d  = ld_wdata;
                    starve_d = '0;
                end else if (grant_pipe) begin
                    state_d  = S_ISSUE;
                    owner_d  = OWN_PIPE;
                    addr_d   = alu_out;
                    // A simultaneous load and store is treated as a store.
                    we_d     = mem_we;
                    wdata_d  = reg_out_b;
                    starve_d = ld_req ? (starve_q + SW'(1)) : '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                lat_d   = CW'(1);
            end
            S_WAIT: begin
                if (lat_q == CW'(LATENCY)) begin
                    state_d = S_DONE;
                    lat_d   = '0;
                    if (!we_q) begin
                        if (owner_q == OWN_PIPE) begin
                            mem_out_d = dm_rdata;
                        end else begin
                            ld_rdata_d = dm_rdata;
                        end
                    end
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            S_DONE: begin
                // Always return to IDLE so a request still held during DONE
                // is not issued a second time.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_PIPE;
            starve_q   <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_out_q  <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mem_out_q  <= mem_out_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    assign dm_en    = (state_q == S_ISSUE);
    assign dm_we    = dm_en & we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign busy     = (state_q != S_IDLE);
    assign ld_done  = (state_q == S_DONE) & (owner_q == OWN_LD);
    assign mem_out  = mem_out_q;
    assign ld_rdata = ld_rdata_q;

    // The pipeline stays frozen during its own access and while queued behind
    // a loader access; it is released only in its own DONE cycle.
    assign stall = ~reset & pipe_req & ~((state_q == S_DONE) & (owner_q == OWN_PIPE));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int LAT  = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    // instance with LATENCY=2
    logic        mem_we, mem_re, ld_req, ld_we;
    logic [31:0] alu_out, reg_out_b, ld_addr, ld_wdata;
    logic [31:0] mem_out, ld_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        stall, ld_done, busy, dm_en, dm_we;
    // instance with LATENCY=1
    logic        mem_we_1, mem_re_1, ld_req_1, ld_we_1;
    logic [31:0] alu_out_1, reg_out_b_1, ld_addr_1, ld_wdata_1;
    logic [31:0] mem_out_1, ld_rdata_1, dm_addr_1, dm_wdata_1, dm_rdata_1;
    logic        stall_1, ld_done_1, busy_1, dm_en_1, dm_we_1;

    dmem_access_ctrl #(.LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_we(mem_we), .mem_re(mem_re), .alu_out(alu_out), .reg_out_b(reg_out_b),
        .mem_out(mem_out), .stall(stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_done(ld_done), .busy(busy),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    dmem_access_ctrl #(.LATENCY(LAT1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset),
        .mem_we(mem_we_1), .mem_re(mem_re_1), .alu_out(alu_out_1), .reg_out_b(reg_out_b_1),
        .mem_out(mem_out_1), .stall(stall_1),
        .ld_req(ld_req_1), .ld_we(ld_we_1), .ld_addr(ld_addr_1), .ld_wdata(ld_wdata_1),
        .ld_rdata(ld_rdata_1), .ld_done(ld_done_1), .busy(busy_1),
        .dm_en(dm_en_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
        .dm_rdata(dm_rdata_1)
    );

    // Memory models: read data appears exactly LATENCY cycles after dm_en and
    // is poisoned in every other cycle, so an off-by-one capture shows up.
    logic [31:0] mem0 [0:4095];
    logic [31:0] rd0_a, rd0_b;
    logic        vld0_a, vld0_b;
    always @(posedge clk) begin
        if (dm_en && dm_we) mem0[dm_addr[11:0]] <= dm_wdata;
        rd0_a <= mem0[dm_addr[11:0]];
        rd0_b <= rd0_a;
        if (reset) begin
            vld0_a <= 1'b0;
            vld0_b <= 1'b0;
        end else begin
            vld0_a <= dm_en & ~dm_we;
            vld0_b <= vld0_a;
        end
    end
    assign dm_rdata = vld0_b ? rd0_b : 32'hBAD0_BAD0;

    logic [31:0] mem1 [0:4095];
    logic [31:0] rd1_a;
    logic        vld1_a;
    always @(posedge clk) begin
        if (dm_en_1 && dm_we_1) mem1[dm_addr_1[11:0]] <= dm_wdata_1;
        rd1_a <= mem1[dm_addr_1[11:0]];
        if (reset) vld1_a <= 1'b0;
        else       vld1_a <= dm_en_1 & ~dm_we_1;
    end
    assign dm_rdata_1 = vld1_a ? rd1_a : 32'hBAD0_BAD0;

    typedef struct {
        bit          ld;
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_pipe[$];
    logic [31:0] sb_ld[$];
    logic [31:0] last_mem_out;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    function automatic vec_t mk(bit ld, bit we, bit re, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp, string name);
        vec_t v;
        v.ld = ld; v.we = we; v.re = re; v.addr = addr;
        v.wdata = wdata; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // following IDLE cycle with the request dropped.
    task automatic run_pipe(input vec_t v);
        int          stall_cyc = 0;
        int          en_cnt    = 0;
        int          cyc       = 0;
        bit          done      = 0;
        logic        seen_we   = 1'b0;
        logic [31:0] seen_addr = '0;
        logic [31:0] seen_wd   = '0;
        logic [31:0] exp_out;
        mem_we = v.we; mem_re = v.re; alu_out = v.addr; reg_out_b = v.wdata;
        sb_pipe.push_back(v.exp);
        while (!done && cyc < 30) begin
            @(negedge clk);
            if (dm_en) begin
                en_cnt++;
                seen_we = dm_we; seen_addr = dm_addr; seen_wd = dm_wdata;
            end
            if (stall) stall_cyc++;
            else done = 1;
            if (!done) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        exp_out = sb_pipe.pop_front();
        check({v.name, " completes"}, {31'b0, done}, 32'd1);
        check({v.name, " stall_cycles"}, stall_cyc, LAT + 2);
        check({v.name, " dm_en_pulses"}, en_cnt, 1);
        check1({v.name, " dm_we"}, seen_we, v.we);
        check({v.name, " dm_addr"}, seen_addr, v.addr);
        if (v.we) check({v.name, " dm_wdata"}, seen_wd, v.wdata);
        check1({v.name, " busy_in_done"}, busy, 1'b1);
        check({v.name, " mem_out"}, mem_out, exp_out);
        last_mem_out = v.exp;
        $display("[TB] pipe %s we=%0d re=%0d addr=%08h mem_out=%08h stall_cycles=%0d",
                 v.name, v.we, v.re, v.addr, mem_out, stall_cyc);
        @(posedge clk); #1;
        mem_we = 1'b0; mem_re = 1'b0;
    endtask

    task automatic run_ld(input vec_t v);
        int          cyc      = 0;
        int          stall_hi = 0;
        int          en_cnt   = 0;
        bit          done     = 0;
        logic        seen_we  = 1'b0;
        logic [31:0] exp_rd;
        ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata;
        sb_ld.push_back(v.exp);
        while (!done && cyc < 30) begin
            @(negedge clk);
            if (dm_en) begin
                en_cnt++;
                seen_we = dm_we;
            end
            if (stall) stall_hi++;
            if (ld_done) done = 1;
            else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        exp_rd = sb_ld.pop_front();
        check({v.name, " ld_done_seen"}, {31'b0, done}, 32'd1);
        check({v.name, " cycles_to_done"}, cyc, LAT + 3);
        check({v.name, " stall_high_cycles"}, stall_hi, 0);
        check({v.name, " dm_en_pulses"}, en_cnt, 1);
        check1({v.name, " dm_we"}, seen_we, v.we);
        check({v.name, " ld_rdata"}, ld_rdata, exp_rd);
        check({v.name, " mem_out_held"}, mem_out, last_mem_out);
        $display("[TB] ldr  %s we=%0d addr=%08h ld_rdata=%08h cycles=%0d",
                 v.name, v.we, v.addr, ld_rdata, cyc);
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk);
        check1({v.name, " ld_done_one_cycle"}, ld_done, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_pipe1(input bit we, input bit re, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp, input string name);
        int stall_cyc = 0;
        int en_cnt    = 0;
        int cyc       = 0;
        bit done      = 0;
        mem_we_1 = we; mem_re_1 = re; alu_out_1 = addr; reg_out_b_1 = wdata;
        while (!done && cyc < 30) begin
            @(negedge clk);
            if (dm_en_1) en_cnt++;
            if (stall_1) stall_cyc++;
            else done = 1;
            if (!done) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        check({name, " completes"}, {31'b0, done}, 32'd1);
        check({name, " stall_cycles"}, stall_cyc, LAT1 + 2);
        check({name, " dm_en_pulses"}, en_cnt, 1);
        check({name, " mem_out"}, mem_out_1, exp);
        check1({name, " ld_done"}, ld_done_1, 1'b0);
        check({name, " ld_rdata"}, ld_rdata_1, 32'h0);
        $display("[TB] lat1 %s addr=%08h mem_out=%08h stall_cycles=%0d", name, addr, mem_out_1, stall_cyc);
        @(posedge clk); #1;
        mem_we_1 = 1'b0; mem_re_1 = 1'b0;
        @(posedge clk); #1;
        check({name, " idle_after"}, {31'b0, busy_1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cyc;
        int en;
        bit done;

        reset = 1'b1;
        mem_we = 1'b0; mem_re = 1'b1; alu_out = '0; reg_out_b = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        mem_we_1 = 1'b0; mem_re_1 = 1'b0; alu_out_1 = '0; reg_out_b_1 = '0;
        ld_req_1 = 1'b0; ld_we_1 = 1'b0; ld_addr_1 = '0; ld_wdata_1 = '0;
        last_mem_out = '0;

        vecs.push_back(mk(0, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0,        "st_100"));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h0,        32'hDEADBEEF, "ld_100"));
        vecs.push_back(mk(1, 1, 0, 32'h3,   32'h12345678, 32'h0,        "ldr_wr_3"));
        vecs.push_back(mk(1, 0, 0, 32'h3,   32'h0,        32'h12345678, "ldr_rd_3"));
        vecs.push_back(mk(0, 1, 1, 32'h300, 32'h4000,     32'hDEADBEEF, "both_300"));
        vecs.push_back(mk(0, 0, 1, 32'h300, 32'h0,        32'h4000,     "ld_300"));
        vecs.push_back(mk(1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, "ldr_rd_100"));
        vecs.push_back(mk(1, 1, 0, 32'h104, 32'hA5A5A5A5, 32'hDEADBEEF, "ldr_wr_104"));
        vecs.push_back(mk(0, 0, 1, 32'h104, 32'h0,        32'hA5A5A5A5, "ld_104"));
        vecs.push_back(mk(0, 0, 1, 32'h3,   32'h0,        32'h12345678, "ld_3"));

        // Reset state, with a pipeline request present to show stall is forced low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst stall", stall, 1'b0);
        check1("rst dm_en", dm_en, 1'b0);
        check1("rst dm_we", dm_we, 1'b0);
        check("rst dm_addr", dm_addr, 32'h0);
        check("rst dm_wdata", dm_wdata, 32'h0);
        check("rst mem_out", mem_out, 32'h0);
        check("rst ld_rdata", ld_rdata, 32'h0);
        check1("rst ld_done", ld_done, 1'b0);
        check1("rst busy", busy, 1'b0);
        check("rst mem_out_1", mem_out_1, 32'h0);
        $display("[TB] reset state sampled");
        @(posedge clk); #1;
        reset = 1'b0; mem_re = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].ld) run_ld(vecs[i]);
            else            run_pipe(vecs[i]);
        end

        // Contention: both sides hold their requests; expect four pipeline
        // grants, one loader grant, and the pattern repeating.
        mem_re = 1'b1; alu_out = 32'h100;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h3;
        g = 0; cyc = 0;
        while (g < 10 && cyc < 300) begin
            @(negedge clk);
            if (dm_en) begin
                check($sformatf("grant%0d owner_is_ld", g), {31'b0, dm_addr == 32'h3}, {31'b0, exp_order[g]});
                check1($sformatf("grant%0d stall", g), stall, 1'b1);
                $display("[TB] grant %0d -> %s", g, (dm_addr == 32'h3) ? "LD" : "PIPE");
                g++;
            end
            if (ld_done) begin
                check1("contend ld_done stall", stall, 1'b1);
                check("contend ld_rdata", ld_rdata, 32'h12345678);
            end
            if (!stall) check("contend mem_out", mem_out, 32'hDEADBEEF);
            @(posedge clk); #1;
            cyc++;
        end
        check("contend grant_count", g, 10);
        mem_re = 1'b0; ld_req = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check1("contend drained", busy, 1'b0);

        // Reset in the second WAIT cycle of a pipeline load.
        mem_re = 1'b1; alu_out = 32'h300;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check1("midrst busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check1("midrst stall_forced", stall, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst mem_out", mem_out, 32'h0);
        check1("midrst dm_en", dm_en, 1'b0);
        check1("midrst busy", busy, 1'b0);
        check1("midrst stall_after", stall, 1'b1);
        en = 0; cyc = 0; done = 0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (dm_en) en++;
            if (!stall) done = 1;
            cyc++;
        end
        check("midrst reissue_completes", {31'b0, done}, 32'd1);
        check("midrst reissue_count", en, 1);
        check("midrst mem_out_after", mem_out, 32'h4000);
        $display("[TB] reset mid-access, reissued %0d time(s), mem_out=%08h", en, mem_out);
        @(posedge clk); #1;
        mem_re = 1'b0;
        @(posedge clk); #1;

        // LATENCY=1 instance.
        run_pipe1(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0,        "lat1_st_10");
        run_pipe1(1'b0, 1'b1, 32'h10, 32'h0,        32'hCAFEF00D, "lat1_ld_10");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
